// File: rtl/comp_result_tracker.sv
// -----------------------------------------------------------------------------
// comp_result_tracker
//
// Purpose:
//   Consumes the one-hot gt/eq/ls result of a magnitude comparator. It counts
//   accepted results per category and in total, tracks runs of consecutive eq
//   results, and reports a lock once a run reaches RUN_LEN. A valid result
//   that is not one-hot sets a sticky error flag.
//
// Configuration macro:
//   COMP_TRACK_SAT_EN  defined   : the statistics counters saturate at all-ones
//                      undefined : the statistics counters wrap modulo 2^CNT_W
//
// Parameters:
//   CNT_W    width of the gt/eq/ls/total counters (>= 2)
//   RUN_LEN  consecutive eq samples needed to enter LOCKED (1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    gt/eq/ls carry a comparator result this cycle
//   gt, eq, ls  comparator result bits, expected one-hot
//   clr         synchronous clear of statistics, state and error (beats in_valid)
//   gt_cnt      accepted gt samples
//   eq_cnt      accepted eq samples
//   ls_cnt      accepted ls samples
//   total_cnt   accepted samples
//   run_cnt     current consecutive-eq run length, saturates at RUN_LEN
//   state       00 IDLE, 01 TRACK, 10 LOCKED
//   match_lock  high while state is LOCKED
//   onehot_err  sticky: some valid sample was not one-hot
//
// Every output comes straight from a register; a sample taken at a rising
// edge is visible on the outputs right after that edge.
// -----------------------------------------------------------------------------
module comp_result_tracker #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             ls,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] ls_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic [7:0]       run_cnt,
  output logic [1:0]       state,
  output logic             match_lock,
  output logic             onehot_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  localparam logic [7:0]       RUN_MAX = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Statistics counter step; the overflow policy lives only here.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef COMP_TRACK_SAT_EN
    bump = (&v) ? v : v + CNT_ONE;
`else
    bump = v + CNT_ONE;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] ls_q, ls_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [7:0]       run_q, run_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  logic             is_onehot;
  logic [7:0]       run_inc;

  // Exactly one of three bits set: odd parity rules out 000/011/101/110,
  // the AND term rules out 111.
  assign is_onehot = (gt ^ eq ^ ls) & ~(gt & eq & ls);

  // Next run length for an eq sample, holding at RUN_LEN.
  assign run_inc = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 8'd1;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    ls_d    = ls_q;
    tot_d   = tot_q;
    run_d   = run_q;
    err_d   = err_q;

    if (clr) begin
      // Clear wins over a coincident sample; that sample is dropped.
      state_d = ST_IDLE;
      gt_d    = '0;
      eq_d    = '0;
      ls_d    = '0;
      tot_d   = '0;
      run_d   = '0;
      err_d   = 1'b0;
    end else if (in_valid) begin
      if (is_onehot) begin
        tot_d = bump(tot_q);
        if (eq) begin
          eq_d  = bump(eq_q);
          run_d = run_inc;
          // Reaching RUN_LEN locks; already-locked runs stay at RUN_LEN and
          // therefore remain locked. With RUN_LEN=1 this goes from IDLE
          // straight to LOCKED.
          state_d = (run_inc == RUN_MAX) ? ST_LOCKED : ST_TRACK;
        end else begin
          if (gt) begin
            gt_d = bump(gt_q);
          end else begin
            ls_d = bump(ls_q);
          end
          run_d   = '0;
          state_d = ST_TRACK;
        end
      end else begin
        // Malformed result: statistics untouched, run broken, error latched.
        run_d   = '0;
        err_d   = 1'b1;
        state_d = ST_TRACK;
      end
    end
  end

  // Lock flag is registered alongside the state so it has no output logic.
  assign lock_d = (state_d == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gt_q    <= '0;
      eq_q    <= '0;
      ls_q    <= '0;
      tot_q   <= '0;
      run_q   <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      ls_q    <= ls_d;
      tot_q   <= tot_d;
      run_q   <= run_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign gt_cnt     = gt_q;
  assign eq_cnt     = eq_q;
  assign ls_cnt     = ls_q;
  assign total_cnt  = tot_q;
  assign run_cnt    = run_q;
  assign state      = state_q;
  assign match_lock = lock_q;
  assign onehot_err = err_q;

endmodule
